mem_bus_master: RTL and testbench



---
 rtl/mem_bus_master.sv | 189 ++++++++++++++++++
 tb/tb_mem_bus_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Single-request load/store bus initiator for the MIPS data RAM (big-endian lanes).
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_bus_master #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RESP} state_t;

   localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);

   state_t      state_q, state_d;
   logic        alive_q;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        err_q, err_d;

   logic        is_byte, is_half;
   logic [1:0]  off_n;
   logic [3:0]  be_n;
   logic [31:0] wd_n;
   logic        trap;

   assign is_byte = (req_size == 2'b00);
   assign is_half = (req_size == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = (is_half & req_addr[0]) |
                 (!is_byte & !is_half & (req_addr[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   // Offset is forced to natural alignment; with the trap on, misaligned never reach the bus.
   always_comb begin
      off_n = 2'b00;
      be_n  = 4'b1111;
      wd_n  = req_wdata;
      unique case (1'b1)
         is_byte: begin
            off_n = req_addr[1:0];
            be_n  = 4'b0001 << req_addr[1:0];
            wd_n  = {4{req_wdata[7:0]}};
         end
         is_half: begin
            off_n = {req_addr[1], 1'b0};
            be_n  = req_addr[1] ? 4'b1100 : 4'b0011;
            wd_n  = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   logic [7:0]  lane;
   logic [15:0] hword;
   logic [31:0] ext;

   always_comb begin
      lane  = 8'h00;
      hword = off_q[1] ? readdata[15:0] : readdata[31:16];
      ext   = readdata;
      unique case (off_q)
         2'd0: lane = readdata[31:24];
         2'd1: lane = readdata[23:16];
         2'd2: lane = readdata[15:8];
         2'd3: lane = readdata[7:0];
         default: ;
      endcase
      unique case (1'b1)
         (size_q == 2'b00): ext = {{24{sgn_q & lane[7]}}, lane};
         (size_q == 2'b01): ext = {{16{sgn_q & hword[15]}}, hword};
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      off_d   = off_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      be_d    = be_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid && alive_q) begin
               wr_d    = req_write;
               size_d  = req_size;
               sgn_d   = req_signed;
               off_d   = off_n;
               addr_d  = {req_addr[31:2], 2'b00};
               wdata_d = wd_n;
               be_d    = be_n;
               rdata_d = 32'h0;
               cnt_d   = 2'd0;
               err_d   = trap;
               state_d = trap ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            if (!waitrequest) begin
               cnt_d   = 2'd0;
               state_d = wr_q ? RESP : RDATA;
            end
         end
         RDATA: begin
            if (cnt_q == LAST) begin
               rdata_d = ext;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         alive_q <= 1'b0;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         off_q   <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         be_q    <= 4'h0;
         cnt_q   <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
         wr_q    <= wr_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign req_ready  = (state_q == IDLE) & alive_q;
   assign read       = (state_q == ISSUE) & !wr_q;
   assign write      = (state_q == ISSUE) & wr_q;
   assign resp_valid = (state_q == RESP);
   assign resp_err   = (state_q == RESP) & err_q;
   assign resp_rdata = rdata_q;
   assign address    = addr_q;
   assign byteenable = be_q;
   assign writedata  = wdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: latency 1 main instance plus a latency 3 instance.
// Honors MEM_MISALIGN_TRAP_EN for the misaligned cases.
module tb_mem_bus_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_valid3 = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        waitrequest = 1'b0;
   logic        stall3 = 1'b0;

   logic        req_ready, resp_valid, resp_err, read, write;
   logic [31:0] resp_rdata, address, writedata, readdata;
   logic [3:0]  byteenable;

   logic        req_ready3, resp_valid3, resp_err3, read3, write3;
   logic [31:0] resp_rdata3, address3, writedata3, readdata3;
   logic [3:0]  byteenable3;

   always #5 clk = ~clk;

   mem_bus_master #(.READ_LATENCY(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .address(address), .read(read), .write(write),
      .byteenable(byteenable), .writedata(writedata),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   mem_bus_master #(.READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid3), .req_ready(req_ready3),
      .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid3), .resp_rdata(resp_rdata3),
      .resp_err(resp_err3),
      .address(address3), .read(read3), .write(write3),
      .byteenable(byteenable3), .writedata(writedata3),
      .waitrequest(stall3), .readdata(readdata3)
   );

   // Word RAM; read data follows the last accepted read address.
   logic [31:0] mem [0:63];
   logic [5:0]  ra, ra3;
   int          cyc = 0;
   int          rd_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (read) rd_cnt <= rd_cnt + 1;
      if (read && !waitrequest) ra <= address[7:2];
      if (read3) ra3 <= address3[7:2];
      if (write && !waitrequest)
         for (int k = 0; k < 4; k++)
            if (byteenable[k])
               mem[address[7:2]][31-8*k -: 8] <= writedata[31-8*k -: 8];
   end

   assign readdata  = mem[ra];
   assign readdata3 = mem[ra3];

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   always @(negedge clk) begin
      if (!reset) chk("strb_excl", 32'(read && write), 32'h0);
      if (resp_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_resp", 32'h1, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata", resp_rdata, e.rdata);
            chk("err", 32'(resp_err), 32'(e.err));
            chk("resp_cyc", cyc, e.cyc);
         end
      end
   end

   // n is the cycle (acceptance edge = 0) in which resp_valid is expected.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, input logic e, input int n);
      exp_t x;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      if (!req_ready) chk("rdy_to", 32'h0, 32'h1);
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h5555_5555;
      x.rdata = exp;
      x.err   = e;
      x.cyc   = cyc + n - 1;
      sb.push_back(x);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         chk("resp_to", 32'(sb.size()), 32'h0);
         sb.delete();
      end
   endtask

   int r0, a3;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_strb", {30'h0, read, write}, 32'h0);
      chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
      chk("rst_addr", address, 32'h0);
      chk("rst_be", 32'(byteenable), 32'h0);
      chk("rst_wdata", writedata, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("rel_ready", 32'(req_ready), 32'h1);

      // Word store / load
      issue(1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 32'h0, 0, 2);
      @(negedge clk);
      chk("sw_write", 32'(write), 32'h1);
      chk("sw_be", 32'(byteenable), 32'hF);
      chk("sw_wdata", writedata, 32'hDEADBEEF);
      chk("sw_addr", address, 32'h40);
      wait_done();
      issue(0, 2'b10, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 3);
      wait_done();

      // Byte store into lane 1
      issue(1, 2'b00, 0, 32'h41, 32'h000000A5, 32'h0, 0, 2);
      @(negedge clk);
      chk("sb_be", 32'(byteenable), 32'h2);
      chk("sb_wdata", writedata, 32'hA5A5A5A5);
      wait_done();
      issue(0, 2'b11, 0, 32'h40, 32'h0, 32'hDEA5BEEF, 0, 3);
      wait_done();

      // Extension
      issue(0, 2'b01, 1, 32'h42, 32'h0, 32'hFFFFBEEF, 0, 3);
      wait_done();
      issue(0, 2'b01, 0, 32'h42, 32'h0, 32'h0000BEEF, 0, 3);
      wait_done();
      issue(0, 2'b00, 1, 32'h41, 32'h0, 32'hFFFFFFA5, 0, 3);
      wait_done();
      issue(0, 2'b00, 0, 32'h43, 32'h0, 32'h000000EF, 0, 3);
      wait_done();
      issue(0, 2'b00, 1, 32'h40, 32'h0, 32'hFFFFFFDE, 0, 3);
      wait_done();
      issue(0, 2'b01, 1, 32'h40, 32'h0, 32'hFFFFDEA5, 0, 3);
      wait_done();
      issue(0, 2'b10, 1, 32'h40, 32'h0, 32'hDEA5BEEF, 0, 3);
      wait_done();

      // Stall: waitrequest high for three edges
      waitrequest = 1'b1;
      issue(0, 2'b10, 0, 32'h40, 32'h0, 32'hDEA5BEEF, 0, 6);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_read", 32'(read), 32'h1);
         chk("stall_addr", address, 32'h40);
         if (i == 3) waitrequest = 1'b0;
      end
      wait_done();

      // Latency 3 instance
      req_write  = 1'b0;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_addr   = 32'h40;
      req_valid3 = 1'b1;
      @(posedge clk);
      #1;
      req_valid3 = 1'b0;
      a3 = cyc;
      @(negedge clk);
      chk("l3_strb", {30'h0, read3, write3}, 32'h2);
      chk("l3_be", 32'(byteenable3), 32'hF);
      chk("l3_addr", address3, 32'h40);
      for (int i = 0; i < 10 && !resp_valid3; i++) @(negedge clk);
      chk("l3_cyc", cyc - a3 + 1, 32'd5);
      chk("l3_data", resp_rdata3, 32'hDEA5BEEF);
      chk("l3_err", 32'(resp_err3), 32'h0);

      // Misaligned accesses
      r0 = rd_cnt;
`ifdef MEM_MISALIGN_TRAP_EN
      issue(0, 2'b10, 0, 32'h42, 32'h0, 32'h0, 1, 1);
      wait_done();
      issue(0, 2'b01, 1, 32'h43, 32'h0, 32'h0, 1, 1);
      wait_done();
      chk("trap_noread", rd_cnt - r0, 32'h0);
`else
      issue(0, 2'b10, 0, 32'h42, 32'h0, 32'hDEA5BEEF, 0, 3);
      @(negedge clk);
      chk("mis_addr", address, 32'h40);
      wait_done();
      issue(0, 2'b01, 1, 32'h43, 32'h0, 32'hFFFFBEEF, 0, 3);
      wait_done();
      chk("mis_reads", rd_cnt - r0, 32'h2);
`endif

      // Half store, back-to-back with a load
      issue(1, 2'b01, 0, 32'h40, 32'h00001234, 32'h0, 0, 2);
      @(negedge clk);
      chk("sh_be", 32'(byteenable), 32'h3);
      chk("sh_wdata", writedata, 32'h12341234);
      wait_done();
      issue(0, 2'b10, 0, 32'h40, 32'h0, 32'h1234BEEF, 0, 3);
      wait_done();

      // Reset during RDATA
      issue(0, 2'b10, 0, 32'h40, 32'h0, 32'h1234BEEF, 0, 3);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      #1;
      chk("rstmid_read", 32'(read), 32'h0);
      chk("rstmid_resp", 32'(resp_valid), 32'h0);
      chk("rstmid_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rstmid_rel", 32'(req_ready), 32'h1);
      repeat (5) @(negedge clk);
      issue(0, 2'b10, 0, 32'h40, 32'h0, 32'h1234BEEF, 0, 3);
      wait_done();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
